alu_mul_sequencer: RTL and testbench

- Multi-cycle unsigned shift-and-add multiplier for the EX stage. It produces the low WIDTH bits of op_a*op_b (RISC-V MUL).
- All arithmetic goes through one instance of the 64-bit ALU. The block sequences that ALU between ADD (accumulate) and SHIFT-LEFT (multiplicand doubling) cycles.
- The pipeline hazard unit stalls on busy and consumes the result through a valid/ack handshake.

---
 rtl/alu_defs.sv | 20 ++
 rtl/ALU_64_bit.sv | 40 ++++
 rtl/alu_mul_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// Shared definitions for the EX-stage ALU and the multiply sequencer.
//   ALU opcodes : 4-bit operation select for ALU_64_bit.
//   seq_state_t : state encoding of the shift-and-add multiply sequencer.
package alu_defs;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/ALU_64_bit.sv
// Combinational EX-stage ALU.
// Ports:
//   a, b    : WIDTH-bit operands
//   alu_op  : operation select (alu_defs ALU_* opcodes)
//   result  : WIDTH-bit result, all arithmetic modulo 2^WIDTH
//   zero    : result == 0
//   lt      : signed a < b
module ALU_64_bit
  import alu_defs::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             lt
);

  localparam int SHW = $clog2(WIDTH);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_NOR: result = ~(a | b);
      // Shift amount uses only the low log2(WIDTH) bits of b.
      ALU_SLL: result = a << b[SHW-1:0];
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign lt   = ($signed(a) < $signed(b));

endmodule

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned shift-and-add multiplier producing the low WIDTH
// bits of op_a*op_b. Every add and shift is performed by one shared ALU
// instance, alternating ADD (accumulate) and SLL (multiplicand doubling).
//
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   flush               : abort any operation, return to IDLE
//   start, op_a, op_b   : request and operands, accepted only while ready=1
//   ready               : high only in IDLE
//   busy                : high in ITER, SHIFT or DONE
//   result              : product low bits, stable while result_valid=1
//   result_valid        : high in DONE until result_ack
//   result_ack          : consumer takes result
//
// Handshake: a request transfers on a rising edge where start=1 and
// ready=1 (flush=0). A result transfers on a rising edge where
// result_valid=1 and result_ack=1; result and result_valid hold until then.
// A start seen in the same cycle as the ack is dropped, since ready is low.
module alu_mul_sequencer
  import alu_defs::*;
#(
  parameter int WIDTH      = 64,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ack
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(WIDTH);

  seq_state_t       state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] mcand, mcand_n;
  logic [WIDTH-1:0] mplier, mplier_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] result_q, result_n;

  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic             alu_zero, alu_lt;
  logic             terminate;

  ALU_64_bit #(.WIDTH(WIDTH)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .alu_op (alu_op),
    .result (alu_result),
    .zero   (alu_zero),
    .lt     (alu_lt)
  );

  // Flags are not needed by the multiplier.
  logic unused_alu_flags;
  assign unused_alu_flags = alu_zero ^ alu_lt;

  // Loop ends after WIDTH iterations, or early once no multiplier bits remain.
  assign terminate = (count == COUNT_MAX) || (EARLY_EXIT && (mplier == '0));

  // ALU operand muxing: SLL of the multiplicand in SHIFT, otherwise the
  // accumulate form ADD(acc, mcand) is presented.
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = acc;
    alu_b  = mcand;
    if (state == S_SHIFT) begin
      alu_op = ALU_SLL;
      alu_a  = mcand;
      alu_b  = WIDTH'(1);
    end
  end

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    count_n  = count;
    result_n = result_q;
    if (flush) begin
      // Datapath registers are left untouched; only control returns home.
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand_n  = op_a;
            mplier_n = op_b;
            acc_n    = '0;
            count_n  = '0;
            state_n  = S_ITER;
          end
        end
        S_ITER: begin
          if (terminate) begin
            result_n = acc;
            state_n  = S_DONE;
          end else begin
            if (mplier[0]) acc_n = alu_result;
            state_n = S_SHIFT;
          end
        end
        S_SHIFT: begin
          mcand_n  = alu_result;
          mplier_n = mplier >> 1;
          count_n  = count + CW'(1);
          state_n  = S_ITER;
        end
        S_DONE: begin
          if (result_ack) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      result_q <= '0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      mcand    <= mcand_n;
      mplier   <= mplier_n;
      count    <= count_n;
      result_q <= result_n;
    end
  end

  assign ready        = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_DONE);
  assign result       = result_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;

  localparam int W = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // dut0: EARLY_EXIT=1, dut1: EARLY_EXIT=0
  logic         rst0, flush0, start0, ack0, ready0, busy0, rv0;
  logic [W-1:0] a0, b0, res0;
  logic         rst1, flush1, start1, ack1, ready1, busy1, rv1;
  logic [W-1:0] a1, b1, res1;

  alu_mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut0 (
    .clk(clk), .reset(rst0), .flush(flush0), .start(start0),
    .op_a(a0), .op_b(b0), .ready(ready0), .busy(busy0),
    .result(res0), .result_valid(rv0), .result_ack(ack0)
  );

  alu_mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut1 (
    .clk(clk), .reset(rst1), .flush(flush1), .start(start1),
    .op_a(a1), .op_b(b1), .ready(ready1), .busy(busy1),
    .result(res1), .result_valid(rv1), .result_ack(ack1)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q0[$];
  int           lat_q0[$];
  logic [W-1:0] exp_q1[$];
  int           lat_q1[$];
  logic [W-1:0] last_exp0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int bitlen(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  // Monitors: compare on every rising edge of result_valid.
  initial begin : mon0
    logic p = 1'b0;
    logic [W-1:0] e;
    int l;
    forever begin
      @(negedge clk);
      if ((rv0 === 1'b1) && !p) begin
        if (exp_q0.size() == 0) begin
          total++; bad++;
          $display("FAIL dut0_unexpected: got result %h with nothing expected (cycle %0d)", res0, cyc);
        end else begin
          e = exp_q0.pop_front();
          l = lat_q0.pop_front();
          check("dut0_result", res0, e);
          check("dut0_latency", W'(cyc), W'(l));
        end
      end
      p = (rv0 === 1'b1);
    end
  end

  initial begin : mon1
    logic p = 1'b0;
    logic [W-1:0] e;
    int l;
    forever begin
      @(negedge clk);
      if ((rv1 === 1'b1) && !p) begin
        if (exp_q1.size() == 0) begin
          total++; bad++;
          $display("FAIL dut1_unexpected: got result %h with nothing expected (cycle %0d)", res1, cyc);
        end else begin
          e = exp_q1.pop_front();
          l = lat_q1.pop_front();
          check("dut1_result", res1, e);
          check("dut1_latency", W'(cyc), W'(l));
        end
      end
      p = (rv1 === 1'b1);
    end
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic issue0(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_out);
    int n = 0;
    while (!ready0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!ready0) begin
      total++; bad++;
      $display("FAIL dut0_ready_timeout: got ready=0 want 1");
    end
    start0 = 1'b1; a0 = a; b0 = b;
    if (expect_out) begin
      last_exp0 = a * b;
      exp_q0.push_back(a * b);
      lat_q0.push_back(cyc + 2 + 2 * bitlen(b));
    end
    @(posedge clk); #1;
    start0 = 1'b0;
  endtask

  // Wait for the result, keep ack low for 'hold' cycles, then ack.
  task automatic finish0(input int hold);
    int n = 0;
    while (!rv0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!rv0) begin
      total++; bad++;
      $display("FAIL dut0_valid_timeout: got result_valid=0 want 1");
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("dut0_hold_result", res0, last_exp0);
      check("dut0_hold_valid", W'(rv0), W'(1));
    end
    ack0 = 1'b1;
    @(posedge clk); #1;
    ack0 = 1'b0;
    check("dut0_ready_after_ack", W'(ready0), W'(1));
  endtask

  task automatic issue1(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_out);
    start1 = 1'b1; a1 = a; b1 = b;
    if (expect_out) begin
      exp_q1.push_back(a * b);
      lat_q1.push_back(cyc + 2 + 2 * W);
    end
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst0 = 1'b1; flush0 = 1'b0; start0 = 1'b0; ack0 = 1'b0; a0 = '0; b0 = '0;
    rst1 = 1'b1; flush1 = 1'b0; start1 = 1'b0; ack1 = 1'b0; a1 = '0; b1 = '0;
    last_exp0 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", W'(ready0), W'(1));
    check("reset_busy", W'(busy0), W'(0));
    check("reset_valid", W'(rv0), W'(0));
    check("reset_result", res0, '0);
    rst0 = 1'b0; rst1 = 1'b0;
    @(posedge clk); #1;

    // 3*5, n=3, hold ack low five cycles
    issue0(64'd3, 64'd5, 1'b1);
    finish0(5);

    // multiplier zero, then back-to-back start right after ack
    issue0(64'h1234, 64'd0, 1'b1);
    finish0(0);
    issue0(64'd9, 64'd4, 1'b1);
    finish0(1);

    issue0(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1);
    finish0(0);
    issue0(64'h1_0000_0000, 64'h1_0000_0000, 1'b1);
    finish0(2);
    issue0(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1);
    finish0(0);

    // flush at T+3 aborts 7*9
    issue0(64'd7, 64'd9, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush0 = 1'b1;
    @(posedge clk); #1;
    flush0 = 1'b0;
    check("flush_ready", W'(ready0), W'(1));
    check("flush_valid", W'(rv0), W'(0));
    repeat (25) @(posedge clk);
    #1;
    check("flush_no_valid", W'(rv0), W'(0));

    // flush and start together in IDLE: request dropped
    flush0 = 1'b1; start0 = 1'b1; a0 = 64'd11; b0 = 64'd13;
    @(posedge clk); #1;
    flush0 = 1'b0; start0 = 1'b0;
    check("flush_start_busy", W'(busy0), W'(0));
    check("flush_start_ready", W'(ready0), W'(1));

    // start coinciding with ack is ignored
    issue0(64'd2, 64'd3, 1'b1);
    while (!rv0) begin @(posedge clk); #1; end
    ack0 = 1'b1; start0 = 1'b1; a0 = 64'd5; b0 = 64'd5;
    @(posedge clk); #1;
    ack0 = 1'b0; start0 = 1'b0;
    check("ack_start_ready", W'(ready0), W'(1));
    @(posedge clk); #1;
    check("ack_start_not_taken", W'(busy0), W'(0));

    // fixed-length variant: 6*7 takes the full 2*WIDTH+2 cycles
    issue1(64'd6, 64'd7, 1'b1);
    for (int n = 0; n < 200 && !rv1; n++) begin @(posedge clk); #1; end
    ack1 = 1'b1;
    @(posedge clk); #1;
    ack1 = 1'b0;
    check("dut1_ready_after_ack", W'(ready1), W'(1));

    // reset in mid-operation at T+50
    issue1(64'd6, 64'd7, 1'b0);
    repeat (49) @(posedge clk);
    #1;
    check("dut1_busy_mid", W'(busy1), W'(1));
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    check("dut1_rst_ready", W'(ready1), W'(1));
    check("dut1_rst_busy", W'(busy1), W'(0));
    check("dut1_rst_valid", W'(rv1), W'(0));
    check("dut1_rst_result", res1, '0);

    // random operand pairs with random ack delay
    for (int k = 0; k < 300; k++) begin
      logic [W-1:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom} >> $urandom_range(0, 64);
      issue0(ra, rb, 1'b1);
      finish0($urandom_range(0, 10));
    end

    repeat (5) @(posedge clk);
    #1;
    check("dut0_queue_drained", W'(exp_q0.size()), W'(0));
    check("dut1_queue_drained", W'(exp_q1.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
